// File: rtl/mult_pkg.sv
// mult_pkg: FSM state encoding and radix-4 Booth select codes shared by the multiplier slice
package mult_pkg;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam logic [2:0] ZERO = 3'd0, PA = 3'd1, P2A = 3'd2, MA = 3'd3, M2A = 3'd4;
  function automatic logic [2:0] booth_code(input logic [2:0] w);
    return (w == 3'b001 || w == 3'b010) ? PA :
           (w == 3'b011) ? P2A :
           (w == 3'b100) ? M2A :
           (w == 3'b101 || w == 3'b110) ? MA : ZERO;
  endfunction
endpackage

// File: rtl/booth_pp_sel.sv
// booth_pp_sel: combinational radix-4 Booth partial product (0, +/-A, +/-2A) sign-extended to WIDTH+2 bits
module booth_pp_sel import mult_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       win,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH+1:0] pp
);
  logic [WIDTH+1:0] ae;
  logic [2:0] code;
  always_comb begin
    ae = {{2{a[WIDTH-1]}}, a};
    code = booth_code(win);
    pp = code == PA ? ae : code == P2A ? ae << 1 : code == MA ? -ae : code == M2A ? -(ae << 1) : '0;
  end
endmodule

// File: rtl/mult_ash.sv
// mult_ash: arithmetic-right barrel shifter used for early termination (only built with MULT_EARLY_TERM_EN)
`ifdef MULT_EARLY_TERM_EN
module mult_ash #(
  parameter int N  = 67,
  parameter int SW = 6
) (
  input  logic [N-1:0]  d,
  input  logic [SW-1:0] sh,
  output logic [N-1:0]  q
);
  assign q = $signed(d) >>> sh;
endmodule
`endif

// File: rtl/mult_booth_seq.sv
// mult_booth_seq: sequential radix-4 Booth signed multiplier, low WIDTH product bits + overflow flag.
// Define MULT_EARLY_TERM_EN to finish early once the remaining multiplier bits only select zero.
module mult_booth_seq import mult_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);
  localparam int PW = 2 * WIDTH + 3;
  localparam int KW = $clog2(WIDTH / 2);
  logic [1:0] state;
  logic [KW-1:0] k;
  logic [WIDTH-1:0] a_q;
  logic [PW-1:0] p, p_step, p_nxt;
  logic [WIDTH+1:0] pp, sum;
  logic fin;
  booth_pp_sel #(.WIDTH(WIDTH)) u_pp (.win(p[2:0]), .a(a_q), .pp(pp));
  assign sum = p[PW-1 -: WIDTH+2] + pp;
  assign p_step = $signed({sum, p[WIDTH:0]}) >>> 2;
`ifdef MULT_EARLY_TERM_EN
  localparam int SW = $clog2(WIDTH) + 1;
  logic [SW-1:0] sh;
  logic [WIDTH:0] msk, win;
  logic [PW-1:0] p_sh;
  logic et;
  mult_ash #(.N(PW), .SW(SW)) u_ash (.d(p), .sh(sh), .q(p_sh));
  // sh = 2*(remaining steps); msk covers the unconsumed multiplier bits plus q_m1
  always_comb begin
    sh = SW'(WIDTH) - SW'({k, 1'b0});
    msk = ~({(WIDTH+1){1'b1}} << (sh + SW'(1)));
    win = p[WIDTH:0] & msk;
    et = (win == '0) || (win == msk);
    p_nxt = et ? p_sh : p_step;
    fin = et || (k == KW'(WIDTH / 2 - 1));
  end
`else
  assign p_nxt = p_step;
  assign fin = k == KW'(WIDTH / 2 - 1);
`endif
  assign data_resultRDY = state == DONE;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      k <= '0;
      a_q <= '0;
      p <= '0;
      data_result <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_MULT) begin
      state <= RUN;
      k <= '0;
      a_q <= data_operandA;
      p <= {{(WIDTH+2){1'b0}}, data_operandB, 1'b0};
    end else if (state == RUN) begin
      p <= p_nxt;
      k <= k + 1'b1;
      if (fin) begin
        state <= DONE;
        data_result <= p_nxt[WIDTH:1];
        data_exception <= !((&p_nxt[PW-1:WIDTH]) || !(|p_nxt[PW-1:WIDTH]));
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mult_booth_seq.sv
// tb_mult_booth_seq: scoreboard bench for mult_booth_seq (WIDTH=32); honours MULT_EARLY_TERM_EN for latency
module tb_mult_booth_seq;
  logic clock = 1'b0, reset_n = 1'b0, ctrl_MULT = 1'b0;
  logic [31:0] data_operandA = '0, data_operandB = '0, data_result;
  logic data_exception, data_resultRDY;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct { logic [31:0] res; logic exc; int t0; int lat; } exp_t;
  exp_t sb[$];

  mult_booth_seq #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input logic [31:0] b);
`ifdef MULT_EARLY_TERM_EN
    logic signed [32:0] e, s;
    e = {b, 1'b0};
    for (int i = 0; i < 16; i++) begin
      s = e >>> (2 * i);
      if (s == '0 || s == '1) return i + 1;
    end
`endif
    return 16;
  endfunction

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint pr;
    pr = longint'($signed(a)) * longint'($signed(b));
    e.res = pr[31:0];
    e.exc = pr != longint'($signed(e.res));
    e.lat = lat_of(b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = 1'b1;
    @(posedge clock);
    #1 ctrl_MULT = 1'b0;
    e.t0 = cyc;
    sb.delete();
    sb.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clock);
    chk("timeout", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (data_resultRDY) begin
      if (sb.size() == 0) chk("spurious_rdy", 64'(data_resultRDY), 64'd0);
      else begin
        e = sb.pop_front();
        chk("result", 64'(data_result), 64'(e.res));
        chk("exception", 64'(data_exception), 64'(e.exc));
        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
      end
    end
  end

  initial begin
    logic [31:0] va[10], vb[10];
    va = '{32'd3, -32'sd7, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'd7, 32'hFFFFFFFF, 32'd0, 32'h7FFFFFFF, 32'h80000000};
    vb = '{32'd5, 32'd6, 32'd1, 32'd2, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'h12345678, 32'h7FFFFFFF, 32'h80000000};
    #12;
    chk("reset_result", 64'(data_result), 64'd0);
    chk("reset_exc", 64'(data_exception), 64'd0);
    chk("reset_rdy", 64'(data_resultRDY), 64'd0);
    @(negedge clock) reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start(va[i], vb[i]);
      wait_done();
    end
    // restart mid-run: only the second operation may report
    start(32'd9, 32'd9);
    repeat (4) @(posedge clock);
    start(32'd2, 32'd3);
    wait_done();
    // async reset mid-run clears outputs at once and suppresses the pending result
    start(32'd9, 32'd9);
    repeat (7) @(posedge clock);
    #2 reset_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_result", 64'(data_result), 64'd0);
    chk("abort_exc", 64'(data_exception), 64'd0);
    chk("abort_rdy", 64'(data_resultRDY), 64'd0);
    repeat (25) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    start(32'd4, 32'd4);
    wait_done();
    for (int i = 0; i < 1000; i++) begin
      start($urandom, (i % 4 == 0) ? 32'($urandom_range(0, 255)) : $urandom);
      wait_done();
    end
    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
